// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the parametrised sequential square-root core.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, used to size the iteration counter for a count of HALF+1 values.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(v)) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sqrt_param_if.sv
// Start/result handshake bundle for sqrt_param; the master starts operations, the slave computes.
interface sqrt_param_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned HALF = WIDTH / 2;

  logic             init;
  logic [WIDTH-1:0] A;
  logic [HALF-1:0]  result;
  logic [HALF:0]    rem;
  logic             busy;
  logic             done;

  modport master (output init, A, input result, rem, busy, done);
  modport slave  (input init, A, output result, rem, busy, done);
endinterface

// File: rtl/sqrt_step.sv
// One digit of the restoring square-root recurrence: consumes two radicand bits, emits one root bit.
module sqrt_step #(
  parameter int unsigned HALF = 8
) (
  input  logic [HALF-1:0] q_i,
  input  logic [HALF-1:0] r_i,
  input  logic [1:0]      bits_i,
  output logic [HALF-1:0] q_o,
  output logic [HALF:0]   r_o
);
  logic [HALF+1:0] t;
  logic [HALF+1:0] d;
  logic [HALF+1:0] diff;
  logic            ge;

  always_comb begin
    t    = {r_i, bits_i};
    d    = {q_i, 2'b01};
    diff = t - d;
    ge   = (t >= d);
    q_o  = HALF'({q_i, ge});
    // Remainder stays below 2^(HALF+1) for any legal operand, so the top bit of t/diff is always 0.
    r_o  = ge ? (HALF+1)'(diff) : (HALF+1)'(t);
  end
endmodule

// File: rtl/sqrt_param.sv
// Sequential integer square root, one result bit per clock, with floor remainder.
// Define SQRT_ROUND_EN to publish a round-to-nearest (saturating) root instead of the floor.
module sqrt_param
  import sqrt_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned HALF  = WIDTH / 2
) (
  input logic         clk,
  input logic         rst,
  sqrt_param_if.slave bus
);
  localparam int unsigned CW = clog2(HALF + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [HALF-1:0]  q_q, q_d;
  logic [HALF-1:0]  r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [HALF-1:0]  result_q, result_d;
  logic [HALF:0]    rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [HALF-1:0]  q_nxt;
  logic [HALF:0]    r_nxt;
  logic [HALF-1:0]  res_fin;

  sqrt_step #(.HALF(HALF)) u_step (
    .q_i    (q_q),
    .r_i    (r_q),
    .bits_i (a_q[WIDTH-1 -: 2]),
    .q_o    (q_nxt),
    .r_o    (r_nxt)
  );

`ifdef SQRT_ROUND_EN
  // Round up when the floor remainder exceeds the floor root; clamp at the all-ones root.
  always_comb begin
    res_fin = q_nxt;
    if ((r_nxt > {1'b0, q_nxt}) && (q_nxt != '1)) res_fin = q_nxt + HALF'(1);
  end
`else
  assign res_fin = q_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.init) begin
          a_d     = bus.A;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(HALF);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = {a_q[WIDTH-3:0], 2'b00};
        q_d   = q_nxt;
        r_d   = r_nxt[HALF-1:0];
        cnt_d = cnt_q - CW'(1);
        // Published outputs only move on the final digit, so they hold through the run.
        if (cnt_q == CW'(1)) begin
          result_d = res_fin;
          rem_d    = r_nxt;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.rem    = rem_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule
